// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a data-memory request controller.
// Holds loads/stores at the dcache until dhit and stalls the pipe meanwhile.
module ex_mem_reg #(
  parameter int WORD_W   = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enable_EX_MEM,
  input  logic              flush_EX_MEM,
  input  logic              dREN_ID_EX,
  input  logic              dWEN_ID_EX,
  input  logic              WEN_ID_EX,
  input  logic              halt_ID_EX,
  input  logic [REG_W-1:0]  wsel_EX,
  input  logic [WORD_W-1:0] alu_result_EX,
  input  logic [WORD_W-1:0] rdat2_ID_EX,
  input  logic [WORD_W-1:0] next_imemaddr_ID_EX,
  input  logic [WORD_W-1:0] instruction_ID_EX,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic              mem_stall,
  output logic              WEN_EX_MEM,
  output logic              halt_EX_MEM,
  output logic              dREN_EX_MEM,
  output logic [REG_W-1:0]  wsel_EX_MEM,
  output logic [WORD_W-1:0] alu_result_EX_MEM,
  output logic [WORD_W-1:0] dmemload_EX_MEM,
  output logic [WORD_W-1:0] next_imemaddr_EX_MEM,
  output logic [WORD_W-1:0] instruction_EX_MEM,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;

  localparam logic [7:0] MaxWaitCnt = 8'(MAX_WAIT);

  stateT             state, stateNext;
  logic              isLoad, isStore;
  logic [WORD_W-1:0] daddrReg, dstoreReg;
  logic [7:0]        waitCnt, waitNext;
  logic              flushPending;
  logic              reqHit, zeroNow, capture;

  // A flush seen during a request is deferred until dhit so the dcache never sees an abort.
  assign reqHit    = (state == REQ) && dhit;
  assign mem_stall = (state == REQ) && !dhit;
  assign zeroNow   = (flush_EX_MEM && (state != REQ)) || (reqHit && (flushPending || flush_EX_MEM));
  assign capture   = enable_EX_MEM && !mem_stall && !zeroNow;
  assign waitNext  = (waitCnt == 8'hFF) ? waitCnt : waitCnt + 8'd1;

  assign dREN   = (state == REQ) && isLoad;
  assign dWEN   = (state == REQ) && isStore;
  assign daddr  = daddrReg;
  assign dstore = dstoreReg;

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (zeroNow)
      stateNext = IDLE;
    else if (capture)
      stateNext = (dWEN_ID_EX || dREN_ID_EX) ? REQ : IDLE;
    else if (reqHit)
      stateNext = DONE;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      WEN_EX_MEM           <= 1'b0;
      halt_EX_MEM          <= 1'b0;
      dREN_EX_MEM          <= 1'b0;
      wsel_EX_MEM          <= '0;
      alu_result_EX_MEM    <= '0;
      dmemload_EX_MEM      <= '0;
      next_imemaddr_EX_MEM <= '0;
      instruction_EX_MEM   <= '0;
      isLoad               <= 1'b0;
      isStore              <= 1'b0;
      daddrReg             <= '0;
      dstoreReg            <= '0;
    end else if (zeroNow) begin
      WEN_EX_MEM           <= 1'b0;
      halt_EX_MEM          <= 1'b0;
      dREN_EX_MEM          <= 1'b0;
      wsel_EX_MEM          <= '0;
      alu_result_EX_MEM    <= '0;
      dmemload_EX_MEM      <= '0;
      next_imemaddr_EX_MEM <= '0;
      instruction_EX_MEM   <= '0;
    end else begin
      // Load data belongs to the request being retired, so it is taken even on a capture edge.
      if (reqHit && isLoad)
        dmemload_EX_MEM <= dmemload;
      if (capture) begin
        WEN_EX_MEM           <= WEN_ID_EX;
        halt_EX_MEM          <= halt_EX_MEM || halt_ID_EX;
        dREN_EX_MEM          <= dREN_ID_EX;
        wsel_EX_MEM          <= wsel_EX;
        alu_result_EX_MEM    <= alu_result_EX;
        next_imemaddr_EX_MEM <= next_imemaddr_ID_EX;
        instruction_EX_MEM   <= instruction_ID_EX;
        isStore              <= dWEN_ID_EX;
        isLoad               <= dREN_ID_EX && !dWEN_ID_EX;
        if (dREN_ID_EX || dWEN_ID_EX) begin
          daddrReg  <= alu_result_EX;
          dstoreReg <= rdat2_ID_EX;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      waitCnt      <= '0;
      timeout_err  <= 1'b0;
      flushPending <= 1'b0;
    end else if (mem_stall) begin
      waitCnt      <= waitNext;
      timeout_err  <= timeout_err || (waitNext >= MaxWaitCnt);
      flushPending <= flushPending || flush_EX_MEM;
    end else begin
      waitCnt      <= '0;
      flushPending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios then random traffic,
// compared against a transaction-level model of the memory stage.
module tb_ex_mem_reg;

  localparam int MAX_WAIT = 255;

  logic        CLK = 1'b0;
  logic        nRST, enable_EX_MEM, flush_EX_MEM, dREN_ID_EX, dWEN_ID_EX;
  logic        WEN_ID_EX, halt_ID_EX, dhit;
  logic [4:0]  wsel_EX;
  logic [31:0] alu_result_EX, rdat2_ID_EX, next_imemaddr_ID_EX, instruction_ID_EX, dmemload;
  logic        dREN, dWEN, mem_stall, WEN_EX_MEM, halt_EX_MEM, dREN_EX_MEM, timeout_err;
  logic [31:0] daddr, dstore, alu_result_EX_MEM, dmemload_EX_MEM;
  logic [31:0] next_imemaddr_EX_MEM, instruction_EX_MEM;
  logic [4:0]  wsel_EX_MEM;

  int checks = 0;
  int errors = 0;

  // Model: one outstanding request or none; DONE and IDLE look identical from outside.
  logic        mValid = 1'b0;
  logic        mBusy, mIsLoad, mIsStore, mSquash, mTimeout;
  int          mWaited;
  logic [31:0] mAddr, mStoreData, mLoad, mAlu, mNext, mInstr;
  logic        mWen, mHalt, mRen;
  logic [4:0]  mWsel;

  always #5 CLK = ~CLK;

  ex_mem_reg dut (
    .CLK(CLK), .nRST(nRST), .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
    .dREN_ID_EX(dREN_ID_EX), .dWEN_ID_EX(dWEN_ID_EX), .WEN_ID_EX(WEN_ID_EX),
    .halt_ID_EX(halt_ID_EX), .wsel_EX(wsel_EX), .alu_result_EX(alu_result_EX),
    .rdat2_ID_EX(rdat2_ID_EX), .next_imemaddr_ID_EX(next_imemaddr_ID_EX),
    .instruction_ID_EX(instruction_ID_EX), .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .mem_stall(mem_stall),
    .WEN_EX_MEM(WEN_EX_MEM), .halt_EX_MEM(halt_EX_MEM), .dREN_EX_MEM(dREN_EX_MEM),
    .wsel_EX_MEM(wsel_EX_MEM), .alu_result_EX_MEM(alu_result_EX_MEM),
    .dmemload_EX_MEM(dmemload_EX_MEM), .next_imemaddr_EX_MEM(next_imemaddr_EX_MEM),
    .instruction_EX_MEM(instruction_EX_MEM), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    if (mValid) begin
      check("dREN", 32'(dREN), 32'(mBusy && mIsLoad));
      check("dWEN", 32'(dWEN), 32'(mBusy && mIsStore));
      check("daddr", daddr, mAddr);
      check("dstore", dstore, mStoreData);
      check("mem_stall", 32'(mem_stall), 32'(mBusy && !dhit));
      check("WEN_EX_MEM", 32'(WEN_EX_MEM), 32'(mWen));
      check("halt_EX_MEM", 32'(halt_EX_MEM), 32'(mHalt));
      check("dREN_EX_MEM", 32'(dREN_EX_MEM), 32'(mRen));
      check("wsel_EX_MEM", 32'(wsel_EX_MEM), 32'(mWsel));
      check("alu_result_EX_MEM", alu_result_EX_MEM, mAlu);
      check("dmemload_EX_MEM", dmemload_EX_MEM, mLoad);
      check("next_imemaddr_EX_MEM", next_imemaddr_EX_MEM, mNext);
      check("instruction_EX_MEM", instruction_EX_MEM, mInstr);
      check("timeout_err", 32'(timeout_err), 32'(mTimeout));
    end
  endtask

  task automatic clearFields();
    mWen = 0; mHalt = 0; mRen = 0; mWsel = 0;
    mAlu = 0; mLoad = 0; mNext = 0; mInstr = 0;
  endtask

  task automatic modelStep();
    logic hitNow, stall, squash, wasLoad;
    if (!nRST) begin
      clearFields();
      mBusy = 0; mIsLoad = 0; mIsStore = 0; mSquash = 0; mTimeout = 0;
      mWaited = 0; mAddr = 0; mStoreData = 0; mValid = 1;
      return;
    end
    hitNow  = mBusy && dhit;
    stall   = mBusy && !dhit;
    squash  = (flush_EX_MEM && !mBusy) || (hitNow && (mSquash || flush_EX_MEM));
    wasLoad = mIsLoad;
    if (stall) begin
      mWaited = (mWaited < 255) ? mWaited + 1 : 255;
      if (mWaited >= MAX_WAIT) mTimeout = 1;
      mSquash = mSquash || flush_EX_MEM;
    end else begin
      mWaited = 0;
      mSquash = 0;
    end
    if (squash) begin
      clearFields();
      mBusy = 0;
    end else begin
      if (hitNow && wasLoad) mLoad = dmemload;
      if (enable_EX_MEM && !stall) begin
        mWen = WEN_ID_EX; mHalt = mHalt || halt_ID_EX; mRen = dREN_ID_EX;
        mWsel = wsel_EX; mAlu = alu_result_EX; mNext = next_imemaddr_ID_EX;
        mInstr = instruction_ID_EX;
        mBusy = dREN_ID_EX || dWEN_ID_EX;
        mIsStore = dWEN_ID_EX;
        mIsLoad = dREN_ID_EX && !dWEN_ID_EX;
        if (mBusy) begin
          mAddr = alu_result_EX;
          mStoreData = rdat2_ID_EX;
        end
      end else if (hitNow) begin
        mBusy = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, then advance one edge.
  task automatic applyStimulus(input logic rst, en, fl, ren, wen, w, h,
                               input logic [4:0] ws, input logic [31:0] alu, r2,
                               input logic hit, input logic [31:0] load);
    nRST = rst; enable_EX_MEM = en; flush_EX_MEM = fl; dREN_ID_EX = ren; dWEN_ID_EX = wen;
    WEN_ID_EX = w; halt_ID_EX = h; wsel_EX = ws; alu_result_EX = alu; rdat2_ID_EX = r2;
    dhit = hit; dmemload = load;
    next_imemaddr_ID_EX = $urandom;
    instruction_ID_EX = $urandom;
    #1;
    checkOutput();
    modelStep();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic hit);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, hit, 32'hDEADBEEF);
  endtask

  initial begin
    {nRST, enable_EX_MEM, flush_EX_MEM, dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX, dhit} = '0;
    wsel_EX = 0; alu_result_EX = 0; rdat2_ID_EX = 0; dmemload = 0;
    next_imemaddr_ID_EX = 0; instruction_ID_EX = 0;
    @(posedge CLK);
    #1;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
    check("reset_WEN", 32'(WEN_EX_MEM), 32'd0);
    check("reset_dREN", 32'(dREN), 32'd0);

    $display("[TB] alu op");
    applyStimulus(1, 1, 0, 0, 0, 1, 0, 5'd5, 32'h10, 32'd0, 0, 32'd0);
    check("alu_WEN", 32'(WEN_EX_MEM), 32'd1);
    check("alu_wsel", 32'(wsel_EX_MEM), 32'd5);
    check("alu_result", alu_result_EX_MEM, 32'h10);
    check("alu_dREN", 32'(dREN), 32'd0);
    check("alu_dWEN", 32'(dWEN), 32'd0);
    check("alu_stall", 32'(mem_stall), 32'd0);

    $display("[TB] load with three wait cycles");
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 5'd7, 32'h40, 32'd0, 0, 32'd0);
    check("load_dREN", 32'(dREN), 32'd1);
    check("load_daddr", daddr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      check("load_wait_dREN", 32'(dREN), 32'd1);
      check("load_wait_stall", 32'(mem_stall), 32'd1);
    end
    idle(1);
    check("load_data", dmemload_EX_MEM, 32'hDEADBEEF);
    check("load_done_dREN", 32'(dREN), 32'd0);
    idle(0);

    $display("[TB] store with both enables set");
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 5'd0, 32'h80, 32'h1234, 0, 32'd0);
    check("store_dWEN", 32'(dWEN), 32'd1);
    check("store_dREN", 32'(dREN), 32'd0);
    check("store_dstore", dstore, 32'h1234);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 1, 0, 5'd9, 32'h99, 32'h55, 0, 32'd0);
      check("store_hold_alu", alu_result_EX_MEM, 32'h80);
    end
    idle(1);
    idle(0);

    $display("[TB] flush during load");
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 5'd3, 32'h44, 32'd0, 0, 32'd0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
    check("flush_held_dREN", 32'(dREN), 32'd1);
    idle(0);
    idle(1);
    check("flush_WEN", 32'(WEN_EX_MEM), 32'd0);
    check("flush_dREN_EX_MEM", 32'(dREN_EX_MEM), 32'd0);
    check("flush_alu", alu_result_EX_MEM, 32'd0);
    check("flush_dREN", 32'(dREN), 32'd0);

    $display("[TB] sticky halt");
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 5'd0, 32'd0, 32'd0, 0, 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 1, 0, 5'd2, 32'h20, 32'd0, 0, 32'd0);
    check("halt_sticky", 32'(halt_EX_MEM), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
    check("halt_reset", 32'(halt_EX_MEM), 32'd0);

    $display("[TB] store timeout");
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 5'd0, 32'h90, 32'hCAFE, 0, 32'd0);
    for (int i = 0; i < MAX_WAIT - 1; i++) idle(0);
    check("timeout_early", 32'(timeout_err), 32'd0);
    idle(0);
    check("timeout_set", 32'(timeout_err), 32'd1);
    check("timeout_stall", 32'(mem_stall), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
    check("timeout_rst_dWEN", 32'(dWEN), 32'd0);
    check("timeout_rst_err", 32'(timeout_err), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic en;
      en = ($urandom % 2) == 0;
      applyStimulus(($urandom % 50) != 0, en, ($urandom % 8) == 0,
                    ($urandom % 3) == 0, ($urandom % 3) == 0,
                    ($urandom % 2) == 0, ($urandom % 16) == 0,
                    5'($urandom), $urandom, $urandom,
                    !en && (($urandom % 3) == 0), $urandom);
    end
    idle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register plus data-memory request controller, directly downstream of the ID/EX register and the ALU.
- Latches EX-stage results and control bits, then drives dREN/dWEN/daddr/dstore to the dcache.
- Holds each request until dhit and raises mem_stall to the hazard unit meanwhile.
- Captures load data for the MEM/WB stage.

Parameters:
- WORD_W, 32, datapath/address width.
- REG_W, 5, register-select width.
- MAX_WAIT, 255, cycles in REQ before the sticky timeout flag sets (8-bit counter, saturating).

Ports:
- CLK  in  1  system clock; sole clock, all state updates on rising edge.
- nRST  in  1  synchronous active-low reset.
- enable_EX_MEM  in  1  capture new EX results this cycle.
- flush_EX_MEM  in  1  squash the instruction in this stage.
- dREN_ID_EX  in  1  load request from EX.
- dWEN_ID_EX  in  1  store request from EX.
- WEN_ID_EX  in  1  register write-back enable.
- halt_ID_EX  in  1  halt instruction marker.
- wsel_EX  in  REG_W  destination register (after reg_dest mux).
- alu_result_EX  in  WORD_W  ALU output / memory address.
- rdat2_ID_EX  in  WORD_W  store data.
- next_imemaddr_ID_EX  in  WORD_W  PC+4 for link write-back.
- instruction_ID_EX  in  WORD_W  pass-through for tracker.
- dhit  in  1  dcache completion.
- dmemload  in  WORD_W  dcache load data.
- dREN  out  1  to dcache.
- dWEN  out  1  to dcache.
- daddr  out  WORD_W  to dcache.
- dstore  out  WORD_W  to dcache.
- mem_stall  out  1  to hazard unit.
- WEN_EX_MEM, halt_EX_MEM, dREN_EX_MEM  out  1 each  registered control.
- wsel_EX_MEM  out  REG_W  registered destination.
- alu_result_EX_MEM, dmemload_EX_MEM, next_imemaddr_EX_MEM, instruction_EX_MEM  out  WORD_W  registered data.
- timeout_err  out  1  sticky: dhit not seen within MAX_WAIT.

Behaviour:
- Reset (nRST=0 at edge): every registered output 0; state IDLE; wait_cnt 0; flush_pending 0; timeout_err 0. Since dREN, dWEN, daddr, dstore and mem_stall derive from registers, all read 0.
- States:
  - IDLE: no request outstanding.
  - REQ: request presented to the dcache.
  - DONE: request complete, result held.
- Capture: at an edge with enable_EX_MEM=1 and mem_stall=0, all *_EX_MEM fields load from the inputs.
  - If dWEN_ID_EX=1, go to REQ as a store; dREN is ignored when both are set.
  - Else if dREN_ID_EX=1, go to REQ as a load.
  - Else go to IDLE.
  - Latency: one cycle from capture to dREN/dWEN high.
- dcache outputs:
  - In REQ: dREN = load, dWEN = store, daddr = alu_result_EX_MEM, dstore = rdat2 captured value.
  - In IDLE/DONE: dREN/dWEN = 0; daddr/dstore hold their last values.
- mem_stall = (state==REQ) & ~dhit, combinational. enable_EX_MEM is ignored while mem_stall=1.
- dhit in REQ: the same edge loads dmemload_EX_MEM (loads only), goes to DONE and clears wait_cnt. dhit outside REQ is ignored.
- DONE: holds all outputs until the next capture or flush.
- Flush outside REQ: at the edge, WEN/halt/dREN_EX_MEM = 0, all data fields = 0, state IDLE. Flush has priority over a simultaneous enable.
- Flush in REQ: the request is not aborted. flush_pending is set, and on dhit the zeroing above is applied instead of DONE.
- halt_EX_MEM: once 1, stays 1 until reset; later captures do not clear it.
- wait_cnt: increments each REQ cycle without dhit and saturates at 255. timeout_err sets when wait_cnt reaches MAX_WAIT and is cleared only by reset.
- Reset mid-REQ: request dropped immediately; dREN/dWEN low at the next cycle.

Test Plan:
- Reset, then ALU op (WEN=1, wsel=5, alu_result=0x10, no mem) with enable -> next cycle WEN_EX_MEM=1, wsel_EX_MEM=5, alu_result_EX_MEM=0x10; dREN=dWEN=0; mem_stall=0.
- Load at addr 0x40, dhit after 3 cycles with dmemload=0xDEADBEEF:
  - dREN=1 and daddr=0x40 for 3 cycles; mem_stall=1 for 3 cycles.
  - dmemload_EX_MEM=0xDEADBEEF after the dhit edge; dREN=0 the next cycle.
- Store with dREN=dWEN=1, rdat2=0x1234, addr 0x80 -> dWEN=1, dREN=0, dstore=0x1234; enable pulses during the stall change nothing.
- Flush asserted during load REQ -> request held until dhit; then WEN_EX_MEM=0, dREN_EX_MEM=0, alu_result_EX_MEM=0, state IDLE.
- Halt captured, then ALU op captured -> halt_EX_MEM stays 1; nRST=0 one cycle -> 0.
- Store with dhit withheld 255 cycles -> timeout_err=1 at wait_cnt=255; mem_stall stays 1; nRST mid-REQ -> dWEN=0 and timeout_err=0 next cycle.
